// File: rtl/multiply_divide_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide
// unit. The execute stage drives the master side; the unit is the slave.
interface multiply_divide_unit_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ALU_OP_WIDTH = 4
);
    logic                    start;
    logic [ALU_OP_WIDTH-1:0] op;
    logic                    flush;
    logic [DATA_WIDTH-1:0]   rs;
    logic [DATA_WIDTH-1:0]   rt;
    logic                    busy;
    logic                    done;
    logic                    div_by_zero;
    logic [DATA_WIDTH-1:0]   hi;
    logic [DATA_WIDTH-1:0]   lo;

    modport master (
        output start, op, flush, rs, rt,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, flush, rs, rt,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/multiply_divide_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// MUL/MULU use radix-2 shift-add, DIV/DIVU use restoring division, both on
// operand magnitudes with a final sign-correction step.
// Optional feature macro: MDU_FAST_MUL_EN -- when defined, MUL/MULU complete
// through a single-cycle combinational product instead of the iterative path.
module multiply_divide_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ALU_OP_WIDTH = 4,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MUL  = 1,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MULU = 2,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_DIV  = 3,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_DIVU = 4,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MTHI = 5,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_OP_MTLO = 6
) (
    input logic                    clk,
    input logic                    rst_n,
    multiply_divide_unit_if.slave  bus
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t          state;
    state_t          next_state;

    logic [2*W-1:0]  acc;
    logic [W-1:0]    op_a;
    logic [W-1:0]    src_rs;
    logic [CW-1:0]   count;
    logic            calc_div;
    logic            neg_res;
    logic            neg_rem;
    logic            div_zero;
    logic [W-1:0]    hi_q;
    logic [W-1:0]    lo_q;
    logic            done_q;
    logic            dbz_q;

    logic            is_mul_op;
    logic            is_div_op;
    logic            is_signed_op;
    logic            take;
    logic            launch;
    logic [W-1:0]    rs_mag;
    logic [W-1:0]    rt_mag;
    logic [W:0]      mul_sum;
    logic [W:0]      div_shift;
    logic [W:0]      div_trial;
    logic [2*W-1:0]  iter_next;
    logic [2*W-1:0]  mul_fixed;
    logic [W-1:0]    quot_fixed;
    logic [W-1:0]    rem_fixed;

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

    // Request decode: a request is only taken in IDLE and never alongside flush
    always_comb begin
        is_mul_op    = (bus.op == ALU_OP_MUL) || (bus.op == ALU_OP_MULU);
        is_div_op    = (bus.op == ALU_OP_DIV) || (bus.op == ALU_OP_DIVU);
        is_signed_op = (bus.op == ALU_OP_MUL) || (bus.op == ALU_OP_DIV);
        take         = (state == IDLE) && bus.start && !bus.flush;
`ifdef MDU_FAST_MUL_EN
        launch       = take && is_div_op;
`else
        launch       = take && (is_mul_op || is_div_op);
`endif
        rs_mag       = (is_signed_op && bus.rs[W-1]) ? -bus.rs : bus.rs;
        rt_mag       = (is_signed_op && bus.rt[W-1]) ? -bus.rt : bus.rt;
    end

    // One iteration step: shift-add for multiply, restoring step for divide.
    // acc holds {partial_product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? op_a : {W{1'b0}})};
        div_shift = acc[2*W-1:W-1];
        div_trial = div_shift - {1'b0, op_a};
        if (!calc_div) begin
            iter_next = {mul_sum, acc[W-1:1]};
        end else if (div_trial[W]) begin
            iter_next = {div_shift[W-1:0], acc[W-2:0], 1'b0};
        end else begin
            iter_next = {div_trial[W-1:0], acc[W-2:0], 1'b1};
        end
    end

    // Sign correction of the magnitude result for the final write-back
    always_comb begin
        mul_fixed  = neg_res ? -acc : acc;
        quot_fixed = neg_res ? -acc[W-1:0] : acc[W-1:0];
        rem_fixed  = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*W-1:0] fast_mag;
    logic [2*W-1:0] fast_product;

    // Single-cycle product of the magnitudes, negated when signs differ
    always_comb begin
        fast_mag     = {{W{1'b0}}, rs_mag} * {{W{1'b0}}, rt_mag};
        fast_product = (is_signed_op && (bus.rs[W-1] ^ bus.rt[W-1])) ? -fast_mag : fast_mag;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush overrides everything and returns to IDLE
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (launch) next_state = CALC;
            CALC:    if (count == LAST) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (bus.flush) next_state = IDLE;
    end

    // Datapath: operand capture, iteration, and HI/LO write-back with done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            op_a     <= '0;
            src_rs   <= '0;
            count    <= '0;
            calc_div <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (take && bus.op == ALU_OP_MTHI) begin
                        hi_q <= bus.rs;
                    end else if (take && bus.op == ALU_OP_MTLO) begin
                        lo_q <= bus.rs;
`ifdef MDU_FAST_MUL_EN
                    end else if (take && is_mul_op) begin
                        {hi_q, lo_q} <= fast_product;
                        done_q       <= 1'b1;
`endif
                    end else if (launch) begin
                        calc_div <= is_div_op;
                        op_a     <= is_div_op ? rt_mag : rs_mag;
                        acc      <= {{W{1'b0}}, (is_div_op ? rs_mag : rt_mag)};
                        neg_res  <= is_signed_op && (bus.rs[W-1] ^ bus.rt[W-1]);
                        neg_rem  <= is_signed_op && bus.rs[W-1];
                        div_zero <= is_div_op && (bus.rt == '0);
                        src_rs   <= bus.rs;
                        count    <= '0;
                    end
                end
                CALC: begin
                    if (!bus.flush) begin
                        acc   <= iter_next;
                        count <= count + ONE;
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        if (!calc_div) begin
                            {hi_q, lo_q} <= mul_fixed;
                        end else if (div_zero) begin
                            hi_q <= src_rs;
                            lo_q <= {W{1'b1}};
                        end else begin
                            hi_q <= rem_fixed;
                            lo_q <= quot_fixed;
                        end
                        done_q <= 1'b1;
                        dbz_q  <= calc_div && div_zero;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiply_divide_unit.sv
// Scoreboard testbench for multiply_divide_unit. Stimulus pushes the expected
// HI/LO/div_by_zero into a queue; a monitor pops and compares on every done.
module tb_multiply_divide_unit;
    localparam int W   = 32;
    localparam int OPW = 4;
    localparam logic [OPW-1:0] OP_NONE = 0;
    localparam logic [OPW-1:0] OP_MUL  = 1;
    localparam logic [OPW-1:0] OP_MULU = 2;
    localparam logic [OPW-1:0] OP_DIV  = 3;
    localparam logic [OPW-1:0] OP_DIVU = 4;
    localparam logic [OPW-1:0] OP_MTHI = 5;
    localparam logic [OPW-1:0] OP_MTLO = 6;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    multiply_divide_unit_if #(.DATA_WIDTH(W), .ALU_OP_WIDTH(OPW)) mdu_bus ();

    multiply_divide_unit #(
        .DATA_WIDTH(W), .ALU_OP_WIDTH(OPW),
        .ALU_OP_MUL(OP_MUL), .ALU_OP_MULU(OP_MULU),
        .ALU_OP_DIV(OP_DIV), .ALU_OP_DIVU(OP_DIVU),
        .ALU_OP_MTHI(OP_MTHI), .ALU_OP_MTLO(OP_MTLO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(mdu_bus)
    );

    typedef struct {
        string          name;
        logic [W-1:0]   hi;
        logic [W-1:0]   lo;
        logic           dbz;
    } exp_t;

    exp_t exp_q[$];
    int   check_count = 0;
    int   pass_count  = 0;

    // Single comparison point; every check in the bench goes through here
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    endtask

    // Drive one request so that it is sampled at the next edge (E0), then
    // release start and scramble the operands to prove they were captured
    task automatic applyStimulus(input logic [OPW-1:0] op, input logic [W-1:0] rs, input logic [W-1:0] rt);
        mdu_bus.op    = op;
        mdu_bus.rs    = rs;
        mdu_bus.rt    = rt;
        mdu_bus.start = 1'b1;
        @(posedge clk);
        #1;
        mdu_bus.start = 1'b0;
        mdu_bus.rs    = 32'h5A5A_A5A5;
        mdu_bus.rt    = 32'h0F0F_F0F0;
    endtask

    function automatic int expLatency(input logic [OPW-1:0] op);
`ifdef MDU_FAST_MUL_EN
        if (op == OP_MUL || op == OP_MULU) return 0;
`endif
        return (op == OP_NONE) ? 0 : W + 1;
    endfunction

    // Count edges until done is seen, bounded so a stuck DUT still ends
    task automatic waitDone(input string name, input int expected_edges);
        int edges = 0;
        while (mdu_bus.done !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
        end
        checkOutput({name, "_latency"}, edges, expected_edges);
    endtask

    task automatic runOp(input string name, input logic [OPW-1:0] op, input logic [W-1:0] rs,
                         input logic [W-1:0] rt, input logic [W-1:0] hi, input logic [W-1:0] lo,
                         input logic dbz);
        exp_t e;
        int   lat;
        e.name = name; e.hi = hi; e.lo = lo; e.dbz = dbz;
        exp_q.push_back(e);
        lat = expLatency(op);
        applyStimulus(op, rs, rt);
        if (lat > 0) checkOutput({name, "_busy"}, mdu_bus.busy, 1);
        waitDone(name, lat);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && mdu_bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_done", mdu_bus.done, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput({e.name, "_hi"}, mdu_bus.hi, e.hi);
                checkOutput({e.name, "_lo"}, mdu_bus.lo, e.lo);
                checkOutput({e.name, "_dbz"}, mdu_bus.div_by_zero, e.dbz);
            end
        end
    end

    initial begin
        exp_t e;
        int   edges;
        mdu_bus.start = 1'b0;
        mdu_bus.flush = 1'b0;
        mdu_bus.op    = OP_NONE;
        mdu_bus.rs    = '0;
        mdu_bus.rt    = '0;
        rst_n         = 1'b0;
        #12;
        checkOutput("reset_hi", mdu_bus.hi, 0);
        checkOutput("reset_lo", mdu_bus.lo, 0);
        checkOutput("reset_busy", mdu_bus.busy, 0);
        checkOutput("reset_done", mdu_bus.done, 0);
        checkOutput("reset_dbz", mdu_bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back arithmetic: each start lands in the previous done cycle
        runOp("mul_neg3x7",  OP_MUL,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        runOp("mulu_max",    OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        runOp("mul_neg5xn6", OP_MUL,  32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0,         32'h1E,        1'b0);
        runOp("div_neg7_2",  OP_DIV,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        runOp("divu_100_7",  OP_DIVU, 32'd100,       32'd7,        32'd2,         32'd14,        1'b0);
        runOp("div_ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0);
        runOp("divu_5_0",    OP_DIVU, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 1'b1);
        runOp("div_neg9_0",  OP_DIV,  32'hFFFF_FFF7, 32'd0,        32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);
        runOp("div_7_neg2",  OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Unknown op with start is ignored
        applyStimulus(OP_NONE, 32'hAAAA, 32'hBBBB);
        checkOutput("badop_busy", mdu_bus.busy, 0);
        checkOutput("badop_hi", mdu_bus.hi, 32'd1);
        checkOutput("badop_lo", mdu_bus.lo, 32'hFFFF_FFFD);
        repeat (3) @(posedge clk);
        #1;

        // MTLO / MTHI visible right after E0, no busy and no done
        applyStimulus(OP_MTLO, 32'h1234, 32'h0);
        checkOutput("mtlo_lo", mdu_bus.lo, 32'h1234);
        checkOutput("mtlo_done", mdu_bus.done, 0);
        checkOutput("mtlo_busy", mdu_bus.busy, 0);
        applyStimulus(OP_MTHI, 32'hABCD, 32'h0);
        checkOutput("mthi_hi", mdu_bus.hi, 32'hABCD);

        // Flush a MUL after E10 together with an ignored start during busy
        applyStimulus(OP_MUL, 32'd3, 32'd4);
        repeat (10) @(posedge clk);
        #1;
        mdu_bus.flush = 1'b1;
        mdu_bus.start = 1'b1;
        mdu_bus.op    = OP_MTHI;
        mdu_bus.rs    = 32'hDEAD;
        @(posedge clk);
        #1;
        mdu_bus.flush = 1'b0;
        mdu_bus.start = 1'b0;
        checkOutput("flush_busy", mdu_bus.busy, 0);
        checkOutput("flush_hi", mdu_bus.hi, 32'hABCD);
        checkOutput("flush_lo", mdu_bus.lo, 32'h1234);
        repeat (40) @(posedge clk);
        #1;
        checkOutput("flush_hi_late", mdu_bus.hi, 32'hABCD);
        checkOutput("flush_lo_late", mdu_bus.lo, 32'h1234);

        // Flush and start together in IDLE: nothing accepted
        mdu_bus.flush = 1'b1;
        mdu_bus.start = 1'b1;
        mdu_bus.op    = OP_MTLO;
        mdu_bus.rs    = 32'h5555;
        @(posedge clk);
        #1;
        mdu_bus.flush = 1'b0;
        mdu_bus.start = 1'b0;
        checkOutput("flushstart_lo", mdu_bus.lo, 32'h1234);

        // Start during busy is ignored and does not disturb the running divide
        e.name = "divu_busy_start"; e.hi = 32'd2; e.lo = 32'd14; e.dbz = 1'b0;
        exp_q.push_back(e);
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        mdu_bus.start = 1'b1;
        mdu_bus.op    = OP_MTHI;
        mdu_bus.rs    = 32'hDEAD;
        @(posedge clk);
        #1;
        mdu_bus.start = 1'b0;
        checkOutput("busy_start_hi", mdu_bus.hi, 32'hABCD);
        waitDone("divu_busy_start", W + 1 - 6);
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a divide
        applyStimulus(OP_DIV, 32'd100, 32'd3);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_hi", mdu_bus.hi, 0);
        checkOutput("arst_lo", mdu_bus.lo, 0);
        checkOutput("arst_busy", mdu_bus.busy, 0);
        checkOutput("arst_done", mdu_bus.done, 0);
        checkOutput("arst_dbz", mdu_bus.div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        edges = 0;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("arst_lo_late", mdu_bus.lo, 0);
        checkOutput("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
